// File: rtl/demux_scan_ctrl.sv
// Channel-scan sequencer driving the data input and select of a 1x8 demux.
// Walks the enabled channels in ascending order, holding each one for a
// programmable dwell time, in either one-shot or continuous mode.
module demux_scan_ctrl #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic               d,
  output logic [2:0]         sel,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CH_N  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               d_q, d_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CH_N-1:0]    mask_q, mask_d;

  logic               has_next;
  logic [SEL_W-1:0]   next_sel;
  logic [SEL_W-1:0]   low_sel;
  logic [SEL_W-1:0]   start_sel;
  logic [DWELL_W-1:0] cnt_last;

  // Channel search: nearest enabled channel above sel, and lowest enabled
  // channel of both the latched mask (wrap) and the live mask (start).
  always_comb begin
    has_next  = 1'b0;
    next_sel  = '0;
    low_sel   = '0;
    start_sel = '0;
    for (int i = int'(CH_N) - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel_q))) begin
        has_next = 1'b1;
        next_sel = SEL_W'(i);
      end
      if (mask_q[i]) begin
        low_sel = SEL_W'(i);
      end
      if (mask[i]) begin
        start_sel = SEL_W'(i);
      end
    end
  end

  // Final count value of a dwell period; dwell_q is never 0 while scanning.
  always_comb begin
    cnt_last = DWELL_W'(dwell_q - DWELL_W'(1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (mask != '0)) begin
          mode_d  = mode;
          dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
          mask_d  = mask;
          sel_d   = start_sel;
          d_d     = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (stop) begin
          d_d     = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q != cnt_last) begin
          cnt_d = DWELL_W'(cnt_q + DWELL_W'(1));
        end else begin
          cnt_d = '0;
          if (has_next) begin
            sel_d = next_sel;
          end else if (mode_q) begin
            sel_d = low_sel;
          end else begin
            d_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        d_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= 1'b0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      dwell_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
    end
  end

  assign d    = d_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl with hand-computed expected sequences.
module tb_demux_scan_ctrl;

  localparam int unsigned DWELL_W = 4;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         mask;
  logic               d;
  logic [2:0]         sel;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_fail   = 0;

  demux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .dwell (dwell),
    .mask  (mask),
    .d     (d),
    .sel   (sel),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Check all four outputs at once.
  task automatic chk_out(input string tag, input logic ed, input logic [2:0] esel,
                         input logic ebusy, input logic edone);
    chk({tag, ".d"},    32'(d),    32'(ed));
    chk({tag, ".sel"},  32'(sel),  32'(esel));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    chk({tag, ".done"}, 32'(done), 32'(edone));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq_a [9] = '{2, 2, 2, 5, 5, 5, 7, 7, 7};
  int seq_c [8] = '{0, 0, 7, 7, 0, 0, 7, 7};

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    dwell = '0;
    mask  = '0;

    // Reset and idle
    tick();
    chk_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    chk_out("idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // One-shot, all channels, dwell 1
    start = 1'b1; mask = 8'hFF; dwell = 4'd1; mode = 1'b0;
    tick();
    start = 1'b0;
    chk_out("ff_ch0", 1'b1, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_out("ff_chn", 1'b1, 3'(i), 1'b1, 1'b0);
    end
    tick();
    chk_out("ff_done", 1'b0, 3'd7, 1'b0, 1'b1);
    tick();
    chk_out("ff_idle", 1'b0, 3'd7, 1'b0, 1'b0);

    // One-shot, mask 1010_0100, dwell 3; mid-scan start/mask/dwell changes ignored
    start = 1'b1; mask = 8'b1010_0100; dwell = 4'd3; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) tick();
      chk_out("a4_scan", 1'b1, 3'(seq_a[j]), 1'b1, 1'b0);
      if (j == 3) begin
        start = 1'b1; mask = 8'hFF; dwell = 4'd1; mode = 1'b1;
      end
      if (j == 5) begin
        start = 1'b0;
      end
    end
    tick();
    chk_out("a4_done", 1'b0, 3'd7, 1'b0, 1'b1);
    tick();
    chk_out("a4_idle", 1'b0, 3'd7, 1'b0, 1'b0);

    // Continuous, mask 81, dwell 2, then stop on an advance cycle
    start = 1'b1; mask = 8'h81; dwell = 4'd2; mode = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) tick();
      chk_out("cont_scan", 1'b1, 3'(seq_c[j]), 1'b1, 1'b0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("cont_stop", 1'b0, 3'd7, 1'b0, 1'b0);
    tick();
    chk_out("cont_after", 1'b0, 3'd7, 1'b0, 1'b0);
    tick();
    chk_out("cont_nodone", 1'b0, 3'd7, 1'b0, 1'b0);

    // Start with empty mask is ignored
    start = 1'b1; mask = 8'h00; dwell = 4'd1; mode = 1'b0;
    tick();
    chk_out("mask0_a", 1'b0, 3'd7, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    chk_out("mask0_b", 1'b0, 3'd7, 1'b0, 1'b0);

    // Dwell 0 treated as 1
    start = 1'b1; mask = 8'h03; dwell = 4'd0; mode = 1'b0;
    tick();
    start = 1'b0;
    chk_out("dw0_ch0", 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    chk_out("dw0_ch1", 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    chk_out("dw0_done", 1'b0, 3'd1, 1'b0, 1'b1);
    tick();
    chk_out("dw0_idle", 1'b0, 3'd1, 1'b0, 1'b0);

    // Asynchronous reset mid-scan
    start = 1'b1; mask = 8'hF0; dwell = 4'd5; mode = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_out("pre_rst", 1'b1, 3'd4, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_out("post_rst", 1'b0, 3'd0, 1'b0, 1'b0);

    // Restart after reset reaches the scan normally
    start = 1'b1; mask = 8'h08; dwell = 4'd1; mode = 1'b0;
    tick();
    start = 1'b0;
    chk_out("restart", 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    chk_out("restart_done", 1'b0, 3'd3, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
